nor_xnor_perm_seq: RTL and testbench
====================================

Name: nor_xnor_perm_seq

Overview:
- Iterative bitsliced 4-bit nonlinear permutation built from the NOR-XNOR primitive, f(a,b,c) = ~(~(a|b)^c) = (a|b)^c.
- Processes LANES nibbles in parallel and performs STEPS Feistel-like rounds, UNROLL rounds per clock.
- Supports forward and inverse direction.
- Sits between the state register and the linear layer in the unmasked cipher datapath, with valid/ready handshakes on both sides.

Parameters:
- LANES, 16, number of 4-bit nibble lanes; data width is 4*LANES.
- STEPS, 8, permutation rounds per operation (>=1).
- UNROLL, 1, rounds computed per clock. STEPS % UNROLL must be 0; otherwise elaboration fails via a generate-time error.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  input word valid
- in_ready  output  1  block can accept a word
- in_data  input  4*LANES  input word; bit 4*j+i = slice i of lane j
- in_inv  input  1  0 = forward, 1 = inverse; sampled with in_data
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- out_data  output  4*LANES  result, same bit mapping as in_data
- busy  output  1  high in RUN

Behaviour:
- Reset: rst_n low asynchronously forces:
  - state = IDLE
  - in_ready = 1, out_valid = 0, busy = 0
  - out_data = 0, step counter = 0, inv flag = 0
- Reset mid-operation aborts the operation. No output is produced for the aborted word.
- Slices: s0..s3, each LANES wide; s_i[j] = data[4*j+i].
- Forward round: t = (s0|s1)^s3; {s0,s1,s2,s3} <= {t,s0,s1,s2}.
- Inverse round: {s0,s1,s2,s3} <= {s1,s2,s3, s0^(s1|s2)}. This is the exact inverse of the forward round.
- Within one clock, UNROLL rounds are chained combinationally in the selected direction.
- FSM IDLE:
  - in_ready = 1.
  - When in_valid is high: latch in_data into the state register, latch in_inv, clear the counter, go to RUN.
- FSM RUN:
  - busy = 1, in_ready = 0.
  - Each clock applies UNROLL rounds and increments the counter.
  - When the counter reaches STEPS/UNROLL-1 on that clock, go to DONE with the final value registered onto out_data.
- FSM DONE:
  - out_valid = 1; out_data is held stable while out_ready is low.
  - When out_ready is high: clear out_valid and go to IDLE.
  - in_ready rises the cycle after the result is taken; there is no overlap in this generation.
- Latency: handshake accepted on edge 0 gives out_valid high after edge STEPS/UNROLL. Throughput is one word per STEPS/UNROLL+2 cycles.
- in_valid outside IDLE is ignored. in_data and in_inv are not sampled.
- out_data is not cleared on leaving DONE; it keeps the last result until the next DONE.
- Counter width is clog2(STEPS/UNROLL)+1 bits. It never wraps, because it is cleared on accept.
- Lanes are fully independent; there is no cross-lane mixing.
- All-zero input maps to all-zero output in both directions.
- Registered outputs: in_ready, out_valid, busy, out_data. No combinational path exists from out_ready to in_ready.

Test Plan:
1. Reset and idle:
   - Assert rst_n=0 mid-RUN (LANES=1, STEPS=8, in_data=4'h1) -> out_valid=0, in_ready=1, busy=0 immediately.
   - With no further handshake -> no out_valid appears.
2. Forward vector, LANES=1, STEPS=8, UNROLL=1:
   - in_data=4'h1, in_inv=0 -> out_data=4'h5, with out_valid rising exactly 8 cycles after accept.
   - in_data=4'h0 -> out_data=4'h0.
3. Inverse and round-trip:
   - in_data=4'h5, in_inv=1 -> out_data=4'h1.
   - For all 16 nibbles, inverse(forward(x))==x.
   - Forward over all 16 inputs yields 16 distinct outputs (bijection).
4. Unroll equivalence:
   - UNROLL=2 and UNROLL=4 with random 64-bit words (LANES=16) -> results match UNROLL=1, with latency 4 and 2 cycles respectively.
5. Backpressure:
   - Hold out_ready=0 for 10 cycles in DONE -> out_data stable, in_ready=0, in_valid pulses ignored.
   - Raise out_ready -> one transfer; in_ready=1 on the next cycle.
6. Lane independence:
   - LANES=16, in_data=64'h0000_0000_0000_0001 -> out_data=64'h0000_0000_0000_0005.
   - All-lanes 4'h1 -> every lane 4'h5.

Source files
------------

// File: rtl/nor_xnor_perm_seq.sv
// nor_xnor_perm_seq: iterative bitsliced 4-bit nonlinear permutation built on
// the NOR-XNOR primitive (a|b)^c. LANES nibbles are processed in parallel, and
// UNROLL rounds are applied per clock until STEPS rounds are done.
// Forward and inverse directions are supported. Both sides use valid/ready.
module nor_xnor_perm_seq #(
  parameter int unsigned LANES  = 16,
  parameter int unsigned STEPS  = 8,
  parameter int unsigned UNROLL = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [4*LANES-1:0]   in_data,
  input  logic                 in_inv,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [4*LANES-1:0]   out_data,
  output logic                 busy
);

  localparam int unsigned UNR_SAFE = (UNROLL == 0) ? 1 : UNROLL;
  localparam int unsigned ITERS    = (STEPS / UNR_SAFE == 0) ? 1 : STEPS / UNR_SAFE;
  localparam int unsigned CW       = $clog2(ITERS) + 1;
  localparam logic [CW-1:0] LAST   = CW'(ITERS - 1);

  generate
    if (UNROLL == 0 || STEPS == 0 || (STEPS % UNR_SAFE) != 0) begin : g_param_check
      $error("nor_xnor_perm_seq: STEPS must be >= 1 and a multiple of UNROLL");
    end
  endgenerate

  // Slice i holds bit i of every lane: s[i][j] = data[4*j+i].
  typedef logic [3:0][LANES-1:0] slices_t;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  function automatic slices_t to_slices(input logic [4*LANES-1:0] d);
    slices_t s;
    s = '0;
    for (int unsigned j = 0; j < LANES; j++)
      for (int unsigned i = 0; i < 4; i++)
        s[i][j] = d[4*j+i];
    return s;
  endfunction

  function automatic logic [4*LANES-1:0] from_slices(input slices_t s);
    logic [4*LANES-1:0] d;
    d = '0;
    for (int unsigned j = 0; j < LANES; j++)
      for (int unsigned i = 0; i < 4; i++)
        d[4*j+i] = s[i][j];
    return d;
  endfunction

  function automatic slices_t fwd_round(input slices_t s);
    slices_t r;
    r[0] = (s[0] | s[1]) ^ s[3];
    r[1] = s[0];
    r[2] = s[1];
    r[3] = s[2];
    return r;
  endfunction

  function automatic slices_t inv_round(input slices_t s);
    slices_t r;
    r[0] = s[1];
    r[1] = s[2];
    r[2] = s[3];
    r[3] = s[0] ^ (s[1] | s[2]);
    return r;
  endfunction

  state_t          state_q, state_nxt;
  slices_t         sl_q, sl_rnd;
  logic            inv_q;
  logic [CW-1:0]   cnt_q;
  logic            load, step, finish;

  // UNROLL rounds chained combinationally in the latched direction.
  always_comb begin
    sl_rnd = sl_q;
    for (int unsigned u = 0; u < UNROLL; u++)
      sl_rnd = inv_q ? inv_round(sl_rnd) : fwd_round(sl_rnd);
  end

  // Next-state and datapath control decode.
  always_comb begin
    state_nxt = state_q;
    load      = 1'b0;
    step      = 1'b0;
    finish    = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          load      = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (cnt_q == LAST) begin
          finish    = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_nxt;
  end

  // Working state, direction flag, round counter and result register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sl_q     <= '0;
      inv_q    <= 1'b0;
      cnt_q    <= '0;
      out_data <= '0;
    end else begin
      if (load) begin
        sl_q  <= to_slices(in_data);
        inv_q <= in_inv;
        cnt_q <= '0;
      end else if (step) begin
        sl_q  <= sl_rnd;
        cnt_q <= cnt_q + 1'b1;
      end
      if (finish) out_data <= from_slices(sl_rnd);
    end
  end

  // Status outputs registered from the next state, so out_ready never
  // reaches in_ready combinationally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      in_ready  <= (state_nxt == IDLE);
      out_valid <= (state_nxt == DONE);
      busy      <= (state_nxt == RUN);
    end
  end

endmodule

// File: tb/tb_nor_xnor_perm_seq.sv
// Testbench for nor_xnor_perm_seq: a single-lane instance plus three 16-lane
// instances (UNROLL 1/2/4) that share their inputs, checked against
// hand-derived vectors and a nibble-table reference model.
module tb_nor_xnor_perm_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Single-lane DUT
  logic       a_in_valid = 1'b0, a_in_inv = 1'b0, a_out_ready = 1'b1;
  logic [3:0] a_in_data = '0;
  logic       a_in_ready, a_out_valid, a_busy;
  logic [3:0] a_out_data;

  nor_xnor_perm_seq #(.LANES(1), .STEPS(8), .UNROLL(1)) u_a (
    .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_data(a_in_data), .in_inv(a_in_inv), .out_valid(a_out_valid),
    .out_ready(a_out_ready), .out_data(a_out_data), .busy(a_busy));

  // 16-lane DUTs with UNROLL = 1, 2, 4
  logic        g_in_valid = 1'b0, g_in_inv = 1'b0, g_out_ready = 1'b1;
  logic [63:0] g_in_data = '0;
  logic        g_in_ready [3];
  logic        g_out_valid[3];
  logic        g_busy     [3];
  logic [63:0] g_out_data [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    nor_xnor_perm_seq #(.LANES(16), .STEPS(8), .UNROLL(1 << g)) u_g (
      .clk(clk), .rst_n(rst_n), .in_valid(g_in_valid), .in_ready(g_in_ready[g]),
      .in_data(g_in_data), .in_inv(g_in_inv), .out_valid(g_out_valid[g]),
      .out_ready(g_out_ready), .out_data(g_out_data[g]), .busy(g_busy[g]));
  end

  int pass_cnt = 0;
  int tot_cnt  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Reference model: the nibble permutation is tabulated once by applying the
  // round rule to a 4-bit value; the inverse table is obtained by inverting
  // that table, not by using the inverse round.
  logic [3:0] fwd_tab[16];
  logic [3:0] inv_tab[16];

  function automatic logic [3:0] fwd_nib(input logic [3:0] x);
    logic s0, s1, s2, s3, t;
    {s3, s2, s1, s0} = x;
    for (int r = 0; r < 8; r++) begin
      t  = (s0 | s1) ^ s3;
      s3 = s2; s2 = s1; s1 = s0; s0 = t;
    end
    return {s3, s2, s1, s0};
  endfunction

  function automatic logic [63:0] model_word(input logic [63:0] d, input logic inv);
    logic [63:0] r;
    r = '0;
    for (int j = 0; j < 16; j++)
      r[4*j +: 4] = inv ? inv_tab[d[4*j +: 4]] : fwd_tab[d[4*j +: 4]];
    return r;
  endfunction

  typedef struct {
    logic [63:0] data;
    logic        inv;
    logic [63:0] exp;
  } vec_t;

  task automatic run_a(input logic [3:0] d, input logic inv, output logic [3:0] res, output int lat);
    int n;
    @(negedge clk);
    n = 0;
    while (!a_in_ready && n < 50) begin @(negedge clk); n++; end
    a_in_valid = 1'b1; a_in_data = d; a_in_inv = inv;
    @(posedge clk); #1;
    a_in_valid = 1'b0; a_in_data = 4'($urandom); a_in_inv = 1'($urandom);
    lat = -1; res = '0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (a_out_valid) begin lat = k; res = a_out_data; break; end
    end
  endtask

  task automatic run_g(input logic [63:0] d, input logic inv,
                       output logic [63:0] res[3], output int lat[3]);
    int n;
    @(negedge clk);
    n = 0;
    while (!(g_in_ready[0] && g_in_ready[1] && g_in_ready[2]) && n < 50) begin
      @(negedge clk); n++;
    end
    g_in_valid = 1'b1; g_in_data = d; g_in_inv = inv;
    @(posedge clk); #1;
    g_in_valid = 1'b0; g_in_data = {$urandom, $urandom}; g_in_inv = 1'($urandom);
    for (int i = 0; i < 3; i++) begin lat[i] = -1; res[i] = '0; end
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      for (int i = 0; i < 3; i++)
        if (g_out_valid[i] && lat[i] < 0) begin lat[i] = k; res[i] = g_out_data[i]; end
      if (lat[0] >= 0 && lat[1] >= 0 && lat[2] >= 0) break;
    end
  endtask

  initial begin
    vec_t        va[6];
    vec_t        vg[4];
    logic [3:0]  ra, rb;
    int          la, lb, ovcnt, n;
    logic [63:0] rg[3];
    int          lg[3];
    logic [15:0] seen;
    logic [63:0] w, e;
    logic        iv;

    for (int x = 0; x < 16; x++) fwd_tab[x] = fwd_nib(4'(x));
    for (int y = 0; y < 16; y++) begin
      inv_tab[y] = '0;
      for (int x = 0; x < 16; x++) if (fwd_tab[x] == 4'(y)) inv_tab[y] = 4'(x);
    end

    // Hand-derived vectors (single lane, 8 forward rounds).
    va[0] = '{64'h1, 1'b0, 64'h5};
    va[1] = '{64'h0, 1'b0, 64'h0};
    va[2] = '{64'h5, 1'b1, 64'h1};
    va[3] = '{64'h0, 1'b1, 64'h0};
    va[4] = '{64'h8, 1'b0, 64'h2};
    va[5] = '{64'h2, 1'b1, 64'h8};
    vg[0] = '{64'h0000_0000_0000_0001, 1'b0, 64'h0000_0000_0000_0005};
    vg[1] = '{64'h1111_1111_1111_1111, 1'b0, 64'h5555_5555_5555_5555};
    vg[2] = '{64'h5555_5555_5555_5555, 1'b1, 64'h1111_1111_1111_1111};
    vg[3] = '{64'h8000_0000_0000_0000, 1'b0, 64'h2000_0000_0000_0000};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_data", 64'(a_out_data), 64'h0);
    chk("rst_in_ready", 64'(a_in_ready), 64'h1);
    chk("rst_out_valid", 64'(a_out_valid), 64'h0);
    chk("rst_busy", 64'(a_busy), 64'h0);
    @(negedge clk); rst_n = 1'b1;

    // Reset in the middle of RUN aborts the word
    @(negedge clk);
    a_in_valid = 1'b1; a_in_data = 4'h1; a_in_inv = 1'b0;
    @(posedge clk); #1; a_in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("midrun_busy", 64'(a_busy), 64'h1);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_out_valid", 64'(a_out_valid), 64'h0);
    chk("abort_in_ready", 64'(a_in_ready), 64'h1);
    chk("abort_busy", 64'(a_busy), 64'h0);
    @(negedge clk); rst_n = 1'b1;
    ovcnt = 0;
    for (int k = 0; k < 12; k++) begin @(posedge clk); #1; if (a_out_valid) ovcnt++; end
    chk("abort_no_output", 64'(ovcnt), 64'h0);

    // Table vectors, single lane
    for (int i = 0; i < 6; i++) begin
      run_a(va[i].data[3:0], va[i].inv, ra, la);
      chk($sformatf("vecA%0d_data", i), 64'(ra), va[i].exp);
      chk($sformatf("vecA%0d_lat", i), 64'(la), 64'd8);
    end

    // Round trip, model agreement and bijection over all nibbles
    seen = '0;
    for (int x = 0; x < 16; x++) begin
      run_a(4'(x), 1'b0, ra, la);
      chk($sformatf("fwd_model_%0d", x), 64'(ra), 64'(fwd_tab[x]));
      seen[ra] = 1'b1;
      run_a(ra, 1'b1, rb, lb);
      chk($sformatf("roundtrip_%0d", x), 64'(rb), 64'(x));
    end
    chk("bijection", 64'(seen), 64'hffff);

    // Table vectors, 16 lanes across all unroll factors
    for (int i = 0; i < 4; i++) begin
      run_g(vg[i].data, vg[i].inv, rg, lg);
      for (int u = 0; u < 3; u++) begin
        chk($sformatf("vecG%0d_u%0d_data", i, 1 << u), rg[u], vg[i].exp);
        chk($sformatf("vecG%0d_u%0d_lat", i, 1 << u), 64'(lg[u]), 64'(8 >> u));
      end
    end

    // Random words against the model
    for (int i = 0; i < 20; i++) begin
      w  = {$urandom, $urandom};
      iv = 1'($urandom);
      e  = model_word(w, iv);
      run_g(w, iv, rg, lg);
      for (int u = 0; u < 3; u++) begin
        chk($sformatf("rand%0d_u%0d_data", i, 1 << u), rg[u], e);
        chk($sformatf("rand%0d_u%0d_lat", i, 1 << u), 64'(lg[u]), 64'(8 >> u));
      end
    end

    // Backpressure in DONE
    @(negedge clk);
    a_out_ready = 1'b0;
    n = 0;
    while (!a_in_ready && n < 50) begin @(negedge clk); n++; end
    a_in_valid = 1'b1; a_in_data = 4'h1; a_in_inv = 1'b0;
    @(posedge clk); #1; a_in_valid = 1'b0;
    n = 0;
    while (!a_out_valid && n < 20) begin @(posedge clk); #1; n++; end
    chk("bp_reach_done", 64'(a_out_valid), 64'h1);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      a_in_valid = 1'($urandom); a_in_data = 4'($urandom); a_in_inv = 1'($urandom);
      @(posedge clk); #1;
      chk($sformatf("bp%0d_data", k), 64'(a_out_data), 64'h5);
      chk($sformatf("bp%0d_in_ready", k), 64'(a_in_ready), 64'h0);
      chk($sformatf("bp%0d_out_valid", k), 64'(a_out_valid), 64'h1);
    end
    @(negedge clk);
    a_in_valid = 1'b0; a_out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_out_valid", 64'(a_out_valid), 64'h0);
    chk("bp_release_in_ready", 64'(a_in_ready), 64'h1);
    chk("bp_release_hold_data", 64'(a_out_data), 64'h5);
    repeat (3) @(posedge clk);
    #1;
    chk("bp_no_stray_accept", 64'(a_busy), 64'h0);

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

  // Global watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
